// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the fetch stage
//
// XLEN             : architectural register / address width
// RESET_PC_DEFAULT : default first fetch address after reset
// fetch_pkt_t      : one buffered instruction and the address it was fetched from
// word_align       : clears the byte-offset bits of an address
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with push, pop and flush
//
// clk_i    : rising-edge clock
// rst_i    : synchronous active-high reset, empties the FIFO
// push_i   : write data_i at the tail (ignored when full unless popping)
// data_i   : write data
// pop_i    : remove the head entry (ignored when empty)
// flush_i  : discard all entries; applied after any same-cycle pop
// data_o   : head entry, valid while empty_o is low
// count_o  : number of stored entries, 0..DEPTH
// full_o   : count_o == DEPTH
// empty_o  : count_o == 0
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with prefetch queue and redirect
//
// clk            : rising-edge clock
// rst            : synchronous active-high reset
// imem_req_*     : word-address request to instruction memory (valid/ready)
// imem_rsp_*     : in-order response, one per accepted request, no backpressure
// redirect_*     : control-flow redirect; flushes the queue and drops stale responses
// out_*          : {instr, pc, pc+4} to the datapath (valid/ready)
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  fetch_pkt_t      push_pkt;
  fetch_pkt_t      head_pkt;

  // Stale in-flight responses will never reach the queue, so they hold no credit.
  assign occupancy = {1'b0, q_count} + {1'b0, inflight_q} - {1'b0, drop_q};

  assign imem_req_valid = !rst && !redirect_valid && (occupancy < CAP);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle belongs to the old path and is discarded.
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop      = out_valid && out_ready;

  // rsp_pc tracks the address of the oldest response that will be kept;
  // requests after a redirect or reset are sequential, so it simply steps by 4.
  assign push_pkt = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

    // Everything still outstanding after this cycle is on the abandoned path.
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      drop_d     = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rsp_keep),
    .data_i  (push_pkt),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (head_pkt),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign out_valid    = !q_empty;
  assign out_instr    = head_pkt.instr;
  assign out_pc       = head_pkt.pc;
  assign out_pc_plus4 = head_pkt.pc + 32'd4;

  // Request credit guarantees a kept response always finds a free slot.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (!q_full || pop));

  a_rsp_has_request : assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  exp_t exp_q[$];
  req_t pend_q[$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = -3;
  int lat       = 1;
  int acc_count = 0;
  int hs_count  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back('{pc: p, instr: mem_word(p)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic probe();
    #3;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: response driven for the whole cycle in which it falls due.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Memory: record accepted requests; reset abandons everything outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        acc_count++;
      end
    end
  end

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h, nothing expected (cycle %0d)", out_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    int h0;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;

    goto(-1);
    probe();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_req_valid", imem_req_valid, 0);

    // Stall from reset: exactly four requests, head holds pc 0.
    goto(0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) expect_pc(32'(i * 4));
    probe();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    goto(1); probe(); chk("req_addr_c1", imem_req_addr, 32'h4);
    goto(2); probe(); chk("req_addr_c2", imem_req_addr, 32'h8);
    goto(3); probe(); chk("req_addr_c3", imem_req_addr, 32'hC);
    goto(9);
    probe();
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_pc", out_pc, 32'h0);
    chk("stall_req_count", acc_count, 4);

    // Release: pcs 0..76 stream out one per cycle.
    goto(10);
    out_ready = 1'b1;
    h0 = hs_count;
    goto(30);
    out_ready = 1'b0;
    chk("throughput", hs_count - h0, 20);
    goto(37);
    probe();
    chk("drain_stream", exp_q.size(), 0);

    // Flush a full queue, then 3-cycle memory with two requests in flight.
    goto(38);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    lat            = 3;
    for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4));
    probe();
    chk("redir_no_req", imem_req_valid, 0);
    goto(39);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    probe();
    chk("redir_addr_200", imem_req_addr, 32'h200);
    goto(41);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    probe();
    chk("redir2_no_req", imem_req_valid, 0);
    goto(42);
    redirect_valid = 1'b0;
    probe();
    chk("redir2_req_valid", imem_req_valid, 1);
    chk("redir2_req_addr", imem_req_addr, 32'h100);
    goto(45); probe(); chk("penalty_out_valid", out_valid, 0);
    goto(46); probe(); chk("redir2_out_valid", out_valid, 1);
    goto(50);
    out_ready = 1'b0;
    goto(59);
    probe();
    chk("drain_redirect", exp_q.size(), 0);

    // Redirect coinciding with handshake of pc 8 and a response; target wraps.
    goto(60);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    lat            = 1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    goto(61);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    goto(65);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    expect_pc(32'h4);
    probe();
    chk("same_cycle_no_req", imem_req_valid, 0);
    goto(66);
    redirect_valid = 1'b0;
    probe();
    chk("same_cycle_q_empty", out_valid, 0);
    chk("wrap_req_addr_f8", imem_req_addr, 32'hFFFF_FFF8);
    goto(68); probe(); chk("wrap_req_addr_0", imem_req_addr, 32'h0);
    goto(72);
    out_ready = 1'b0;
    goto(81);
    probe();
    chk("drain_wrap", exp_q.size(), 0);
    chk("full_out_valid", out_valid, 1);

    // Reset with a full queue.
    goto(82);
    rst = 1'b1;
    probe();
    chk("mid_rst_req_valid", imem_req_valid, 0);
    goto(83);
    probe();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_req_valid2", imem_req_valid, 0);
    goto(84);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    probe();
    chk("post_rst_req_valid", imem_req_valid, 1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    goto(90);
    out_ready = 1'b0;
    goto(96);
    probe();
    chk("drain_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle RISC-V datapath and replaces its combinational PC/instruction-memory path. Issues in-order word requests to an instruction memory with variable latency, buffers returned instructions with their PC in a small prefetch queue, and hands `{instr, pc, pc+4}` downstream over a valid/ready handshake. Branch and jump targets, the PCTarget or ALUResult value selected by PCSrc, arrive as a redirect that flushes the queue and discards stale responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2; also the cap on in-flight plus buffered instructions
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of `clk`
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address; bits [1:0] always 0
- `imem_rsp_valid`  in  1  response valid; in order, one per accepted request, no backpressure, earliest one cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  control-flow redirect
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- `out_valid`  out  1  instruction available
- `out_ready`  in  1  datapath consumes
- `out_instr`  out  32  instruction
- `out_pc`  out  32  its address
- `out_pc_plus4`  out  32  `out_pc + 4`, modulo 2^32

## Operation
- State: `fetch_pc` (32), `inflight` (0..DEPTH), `drop` (0..inflight), queue `count` (0..DEPTH); counter width $clog2(DEPTH)+1.
- Request: `imem_req_valid = !rst && !redirect_valid && (count + inflight - drop) < DEPTH`. `imem_req_addr = fetch_pc`. On accept, `fetch_pc += 4` (wraps 0xFFFF_FFFC→0) and `inflight++`.
- Response: `inflight--`. If `drop > 0`, discard and `drop--`. Otherwise push `{fetch address, data}`. The fetch address comes from a parallel in-order address record (sub-FIFO or pc tag) inside the queue module.
- Credit rule: responses never overflow the queue. Overflow is a design error; flag it with an assertion.
- Output: head of queue. `out_valid = (count != 0)`. Pop on `out_valid && out_ready`.
- Redirect cycle:
  - No request is issued.
  - The queue is flushed after any pop in the same cycle; a same-cycle handshake counts as delivered.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - `drop <= inflight` after this cycle's response is applied.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins, and every older in-flight response is dropped.
- Reset: `fetch_pc = RESET_PC`, `inflight = drop = count = 0`, `out_valid = 0`, `imem_req_valid = 0`. Reset mid-operation abandons outstanding responses; the memory must be reset alongside.

## Timing
- First `imem_req_valid` is in the first cycle with `rst` low.
- Response-to-`out_valid` latency is 1 cycle (registered queue write, no bypass).
- With a 1-cycle memory and `out_ready` held high, the unit sustains 1 instruction per cycle after a 2-cycle fill.
- Redirect penalty: 1 bubble cycle with no request, plus memory latency, plus 1 cycle.
- `out_*` are stable while `out_valid && !out_ready` and no redirect occurs.
- `imem_req_addr` is stable while `imem_req_valid && !imem_req_ready`. A redirect may withdraw a pending request; the memory must tolerate this.

## Structure
- Shared package `rv_pkg`: `XLEN = 32`, `RESET_PC_DEFAULT`, a packed `fetch_pkt_t` of `{pc[31:0], instr[31:0]}`.
- One sub-module: `sync_fifo` (parameterised width/depth; push, pop, flush; count, full, empty) holding `fetch_pkt_t`. All counters and `fetch_pc` stay in `fetch_unit`.

## Test plan
- Reset, 1-cycle memory, `out_ready = 1`: addresses 0,4,8,… issued each cycle; `out_pc` 0,4,8 with matching `out_instr`; `out_pc_plus4` = 4,8,12.
- `out_ready = 0` for 10 cycles: exactly DEPTH = 4 requests issued, `imem_req_valid` drops, `out_*` hold pc 0. On release, pcs 0..12 then 16 appear with no loss.
- 3-cycle memory latency, redirect to 0x0000_0103 with 2 requests in flight: both stale responses discarded; next request addr 0x100; next `out_pc` = 0x100.
- Redirect in the same cycle as an `out` handshake of pc 8 and as a response: pc 8 counted delivered, response dropped, queue empty next cycle.
- `fetch_pc` at 0xFFFF_FFFC: next request addr 0x0; `out_pc_plus4` for 0xFFFF_FFFC = 0x0.
- Assert `rst` mid-stream with queue full: next cycle `out_valid = 0`, `imem_req_valid = 0`; after release the first request address is `RESET_PC`.
